// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Tracks in-flight register writes per architectural register, raises the
// dependency stall, holds Fetch while a branch is unresolved and issues a
// one-cycle redirect once Mem resolves the target. Also counts stall cycles.
// All state updates on the falling edge, matching the pipeline latches.
// Optional build macro: HAZARD_WB_BYPASS_EN lets a source whose last pending
// write is retiring this cycle proceed (needs register-file write-through).
module hazard_stall_ctrl #(
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned REG_IDX_W = 4,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned PC_W      = 16
) (
  input  logic                 I_CLOCK,
  input  logic                 I_RESET,
  input  logic                 I_DecValid,
  input  logic [REG_IDX_W-1:0] I_DecSrc1,
  input  logic [REG_IDX_W-1:0] I_DecSrc2,
  input  logic                 I_DecSrc1V,
  input  logic                 I_DecSrc2V,
  input  logic [REG_IDX_W-1:0] I_DecDest,
  input  logic                 I_DecDestV,
  input  logic                 I_DecIsBranch,
  input  logic                 I_WbValid,
  input  logic [REG_IDX_W-1:0] I_WbDest,
  input  logic                 I_BrResolved,
  input  logic [PC_W-1:0]      I_BrTarget,
  output logic                 O_DepStallSignal,
  output logic                 O_BranchStallSignal,
  output logic                 O_BranchAddrSelect,
  output logic [PC_W-1:0]      O_BranchPC,
  output logic                 O_Issue,
  output logic                 O_ScbErr,
  output logic [15:0]          O_StallCycles
);

  typedef enum logic [1:0] {StIdle, StWait, StRedir} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic                err_q, err_d;
  logic                sel_q, sel_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;

  logic                src1_busy, src2_busy, dest_full;
  logic [NUM_REGS-1:0] inc_vec, dec_vec;

  // Dependency checks against the current pending-write counts
  always_comb begin
    src1_busy = I_DecSrc1V && (cnt_q[I_DecSrc1] != '0);
    src2_busy = I_DecSrc2V && (cnt_q[I_DecSrc2] != '0);
`ifdef HAZARD_WB_BYPASS_EN
    // Last outstanding write lands this cycle; write-through supplies the value
    if (I_WbValid && (I_WbDest == I_DecSrc1) && (cnt_q[I_DecSrc1] == CntOne)) begin
      src1_busy = 1'b0;
    end
    if (I_WbValid && (I_WbDest == I_DecSrc2) && (cnt_q[I_DecSrc2] == CntOne)) begin
      src2_busy = 1'b0;
    end
`endif
    // A saturated counter cannot track another in-flight write
    dest_full = I_DecDestV && (cnt_q[I_DecDest] == CntMax);
  end

  assign O_DepStallSignal    = I_DecValid && (src1_busy || src2_busy || dest_full);
  assign O_Issue             = I_DecValid && !O_DepStallSignal && (state_q == StIdle);
  assign O_BranchStallSignal = (O_Issue && I_DecIsBranch) || (state_q == StWait);
  assign O_BranchAddrSelect  = sel_q;
  assign O_BranchPC          = pc_q;
  assign O_ScbErr            = err_q;
  assign O_StallCycles       = stall_cnt_q;

  // Per-register increment (issue) and decrement (writeback) strobes
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      inc_vec[i] = O_Issue && I_DecDestV && (I_DecDest == REG_IDX_W'(i));
      dec_vec[i] = I_WbValid && (I_WbDest == REG_IDX_W'(i));
    end
  end

  // Scoreboard next state; simultaneous inc/dec on one register cancel out
  always_comb begin
    err_d = err_q;
    if (I_WbValid && (cnt_q[I_WbDest] == '0)) begin
      err_d = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end else if (dec_vec[i] && !inc_vec[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CntOne;
      end
    end
  end

  // Branch FSM: hold Fetch until resolution, then one redirect cycle
  always_comb begin
    state_d = state_q;
    sel_d   = 1'b0;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle: begin
        if (O_Issue && I_DecIsBranch) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (I_BrResolved) begin
          state_d = StRedir;
          sel_d   = 1'b1;
          pc_d    = I_BrTarget;
        end
      end
      StRedir: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Saturating count of cycles spent stalled for any reason
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((O_DepStallSignal || O_BranchStallSignal) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State registers, synchronous reset
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      state_q     <= StIdle;
      err_q       <= 1'b0;
      sel_q       <= 1'b0;
      pc_q        <= '0;
      stall_cnt_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      sel_q       <= sel_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl.
// The driver applies one directed vector per cycle just after the falling
// (active) edge and queues the hand-computed outputs; the monitor pops and
// compares on the rising edge, mid-cycle.
module tb_hazard_stall_ctrl;

`ifdef HAZARD_WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        dec_valid;
  logic [3:0]  src1, src2, dest, wb_dest;
  logic        src1_v, src2_v, dest_v, is_br, wb_valid, br_res;
  logic [15:0] br_tgt;
  logic        dep_stall, br_stall, addr_sel, issue, scb_err;
  logic [15:0] br_pc, stall_cycles;

  typedef struct {
    string       name;
    logic        dep;
    logic        brs;
    logic        iss;
    logic        sel;
    logic [15:0] pc;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] m_cnt    = 16'd0;

  hazard_stall_ctrl dut (
    .I_CLOCK             (clk),
    .I_RESET             (rst),
    .I_DecValid          (dec_valid),
    .I_DecSrc1           (src1),
    .I_DecSrc2           (src2),
    .I_DecSrc1V          (src1_v),
    .I_DecSrc2V          (src2_v),
    .I_DecDest           (dest),
    .I_DecDestV          (dest_v),
    .I_DecIsBranch       (is_br),
    .I_WbValid           (wb_valid),
    .I_WbDest            (wb_dest),
    .I_BrResolved        (br_res),
    .I_BrTarget          (br_tgt),
    .O_DepStallSignal    (dep_stall),
    .O_BranchStallSignal (br_stall),
    .O_BranchAddrSelect  (addr_sel),
    .O_BranchPC          (br_pc),
    .O_Issue             (issue),
    .O_ScbErr            (scb_err),
    .O_StallCycles       (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input string field, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s: got %h required %h", name, field, act, req);
    end
  endtask

  // One cycle of stimulus; expectation queued when chk is set. The stall-count
  // model advances from the expected stall flags, never from the DUT.
  task automatic step(input string name, input logic r, input logic dv,
                      input logic [3:0] s1, input logic s1v, input logic [3:0] s2,
                      input logic s2v, input logic [3:0] d, input logic dvv,
                      input logic br, input logic wbv, input logic [3:0] wbd,
                      input logic brr, input logic [15:0] tgt, input bit chk,
                      input logic e_dep, input logic e_brs, input logic e_iss,
                      input logic e_sel, input logic [15:0] e_pc, input logic e_err);
    exp_t e;
    @(negedge clk);
    #1;
    rst = r; dec_valid = dv; src1 = s1; src1_v = s1v; src2 = s2; src2_v = s2v;
    dest = d; dest_v = dvv; is_br = br; wb_valid = wbv; wb_dest = wbd;
    br_res = brr; br_tgt = tgt;
    if (chk) begin
      e.name = name; e.dep = e_dep; e.brs = e_brs; e.iss = e_iss; e.sel = e_sel;
      e.pc = e_pc; e.err = e_err; e.cnt = m_cnt;
      exp_q.push_back(e);
    end
    if (r) m_cnt = 16'd0;
    else if ((e_dep || e_brs) && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
  endtask

  // Monitor: compare every queued expectation against the live outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.name, "dep_stall", {15'd0, dep_stall}, {15'd0, e.dep});
        cmp(e.name, "br_stall", {15'd0, br_stall}, {15'd0, e.brs});
        cmp(e.name, "issue", {15'd0, issue}, {15'd0, e.iss});
        cmp(e.name, "addr_sel", {15'd0, addr_sel}, {15'd0, e.sel});
        cmp(e.name, "branch_pc", br_pc, e.pc);
        cmp(e.name, "scb_err", {15'd0, scb_err}, {15'd0, e.err});
        cmp(e.name, "stall_cycles", stall_cycles, e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1; dec_valid = 1'b0; src1 = '0; src2 = '0; dest = '0; wb_dest = '0;
    src1_v = 1'b0; src2_v = 1'b0; dest_v = 1'b0; is_br = 1'b0; wb_valid = 1'b0;
    br_res = 1'b0; br_tgt = '0;

    //   name            r  dv s1 s1v s2 s2v d  dv br wbv wbd brr tgt       chk dep brs iss sel pc        err
    step("reset0",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0);
    step("reset1",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0);
    step("rst_state",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0);
    // RAW on r3
    step("iss_d3",        0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0000, 0);
    step("raw_r3",        0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0000, 0);
    step("raw_r3_hold",   0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0000, 0);
    step("raw_r3_wb",     0, 1, 3, 1, 0, 0, 0, 0, 0, 1, 3, 0, 16'h0000, 1, !Byp, 0, Byp, 0,
         16'h0000, 0);
    step("raw_r3_go",     0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0000, 0);
    // Saturate r5 at three in-flight writes
    step("w5_a",          0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0000, 0);
    step("w5_b",          0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0000, 0);
    step("w5_c",          0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0000, 0);
    step("w5_sat",        0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0000, 0);
    step("w5_sat_wb",     0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 5, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0000, 0);
    step("w5_go",         0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0000, 0);
    step("src2_r5",       0, 1, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0000, 0);
    step("srcv_off",      0, 1, 5, 0, 5, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0000, 0);
    // Register 0 is tracked like the others
    step("iss_d0",        0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0000, 0);
    step("raw_r0",        0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0000, 0);
    step("wb_r0",         0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0);
    step("r0_free",       0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0000, 0);
    // Branch, resolve to 0x0040, redirect
    step("br_issue",      0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 1, 0, 1, 1, 0, 16'h0000, 0);
    step("br_wait",       0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 0);
    step("br_resolve",    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0040, 1, 0, 1, 0, 0, 16'h0000, 0);
    step("br_redir",      0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 16'h0040, 0);
    step("br_idle",       0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0040, 0);
    step("brres_ignored", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h1234, 1, 0, 0, 0, 0, 16'h0040, 0);
    step("after_ignore",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0040, 0);
    // Writeback with nothing pending sets the sticky error
    step("wb_r7_err",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0040, 0);
    step("err_set",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0040, 1);
    step("r7_still0",     0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0040, 1);
    // Reset while waiting discards the redirect
    step("br2_issue",     0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 1, 0, 1, 1, 0, 16'h0040, 1);
    step("br2_wait",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0040, 1);
    step("rst_in_wait",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h00AA, 1, 0, 1, 0, 0, 16'h0040, 1);
    step("post_rst",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0);
    step("post_rst_res",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h00BB, 1, 0, 0, 0, 0, 16'h0000, 0);
    step("post_rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0);
    // Long branch wait drives the stall counter into saturation
    step("br3_issue",     0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 1, 0, 1, 1, 0, 16'h0000, 0);
    for (int i = 0; i < 65540; i++) begin
      step("sat_fill",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 0);
    end
    step("sat_check",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 0);
    step("sat_hold",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 0);
    step("br3_resolve",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0FFE, 1, 0, 1, 0, 0, 16'h0000, 0);
    step("br3_redir",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 16'h0FFE, 0);
    step("br3_done",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0FFE, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    if (m_cnt != 16'hFFFF) begin
      $display("note: stall model ended at %h", m_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
